// File: rtl/gpu_frame_scheduler.sv
// Double-buffered blob descriptor front-end for the gpu, committed at vsync start,
// plus a round-robin arbiter merging two sprite-RAM writers onto one port.
module gpu_frame_scheduler #(
  parameter int ram_add_width = 8,
  parameter int NR_OF_BLOBS   = 4,
  parameter int VSYNC_ACT_LOW = 1,
  localparam int IW = (NR_OF_BLOBS > 1) ? $clog2(NR_OF_BLOBS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     v_sync,
  input  logic                     desc_wr_valid,
  output logic                     desc_wr_ready,
  input  logic [IW-1:0]            desc_wr_idx,
  input  logic [2:0]               desc_wr_field,
  input  logic [9:0]               desc_wr_data,
  input  logic                     commit_req,
  output logic                     commit_pending,
  output logic                     commit_done,
  output logic                     sprite_enable [NR_OF_BLOBS],
  output logic [9:0]               x1_pos        [NR_OF_BLOBS],
  output logic [9:0]               y1_pos        [NR_OF_BLOBS],
  output logic [9:0]               x2_pos        [NR_OF_BLOBS],
  output logic [9:0]               y2_pos        [NR_OF_BLOBS],
  output logic [ram_add_width-1:0] ram_address   [NR_OF_BLOBS],
  output logic [1:0]               layer         [NR_OF_BLOBS],
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [ram_add_width-1:0] a_add,
  input  logic [11:0]              a_data,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [ram_add_width-1:0] b_add,
  input  logic [11:0]              b_data,
  output logic [ram_add_width-1:0] wr_add,
  output logic [11:0]              wr_data,
  output logic                     wr_req
);

  localparam logic VS_IDLE = (VSYNC_ACT_LOW != 0);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COMMIT
  } state_e;

  typedef struct packed {
    logic                     en;
    logic [9:0]               x1;
    logic [9:0]               y1;
    logic [9:0]               x2;
    logic [9:0]               y2;
    logic [ram_add_width-1:0] ra;
    logic [1:0]               ly;
  } blob_t;

  state_e state_q, state_d;
  blob_t  sh_q  [NR_OF_BLOBS];
  blob_t  sh_d  [NR_OF_BLOBS];
  blob_t  act_q [NR_OF_BLOBS];
  blob_t  act_d [NR_OF_BLOBS];

  logic                     vs_q;
  logic                     vsync_start;
  logic                     last_b_q, last_b_d;
  logic                     wr_req_q, wr_req_d;
  logic [ram_add_width-1:0] wr_add_q, wr_add_d;
  logic [11:0]              wr_data_q, wr_data_d;

  assign vsync_start = (vs_q == VS_IDLE) && (v_sync != VS_IDLE);

  always_comb begin
    state_d        = state_q;
    sh_d           = sh_q;
    act_d          = act_q;
    desc_wr_ready  = 1'b0;
    commit_pending = 1'b0;
    commit_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        desc_wr_ready = 1'b1;
        if (desc_wr_valid) begin
          // out-of-range indices match no blob and are silently dropped
          for (int i = 0; i < NR_OF_BLOBS; i++) begin
            if (desc_wr_idx == IW'(i)) begin
              case (desc_wr_field)
                3'd0:    sh_d[i].en = desc_wr_data[0];
                3'd1:    sh_d[i].x1 = desc_wr_data;
                3'd2:    sh_d[i].y1 = desc_wr_data;
                3'd3:    sh_d[i].x2 = desc_wr_data;
                3'd4:    sh_d[i].y2 = desc_wr_data;
                3'd5:    sh_d[i].ra = desc_wr_data[ram_add_width-1:0];
                3'd6:    sh_d[i].ly = desc_wr_data[1:0];
                default: ;
              endcase
            end
          end
        end
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        commit_pending = 1'b1;
        if (vsync_start) state_d = COMMIT;
      end
      COMMIT: begin
        commit_done = 1'b1;
        act_d       = sh_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last_b_q set means b won the previous grant, so a wins the next tie
  always_comb begin
    a_ready   = a_valid && (!b_valid || last_b_q);
    b_ready   = b_valid && !a_ready;
    last_b_d  = last_b_q;
    wr_req_d  = a_ready || b_ready;
    wr_add_d  = wr_add_q;
    wr_data_d = wr_data_q;
    if (a_ready) begin
      last_b_d  = 1'b0;
      wr_add_d  = a_add;
      wr_data_d = a_data;
    end else if (b_ready) begin
      last_b_d  = 1'b1;
      wr_add_d  = b_add;
      wr_data_d = b_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      vs_q      <= VS_IDLE;
      last_b_q  <= 1'b1;
      wr_req_q  <= 1'b0;
      wr_add_q  <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < NR_OF_BLOBS; i++) begin
        sh_q[i]  <= '0;
        act_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      vs_q      <= v_sync;
      last_b_q  <= last_b_d;
      wr_req_q  <= wr_req_d;
      wr_add_q  <= wr_add_d;
      wr_data_q <= wr_data_d;
      sh_q      <= sh_d;
      act_q     <= act_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NR_OF_BLOBS; i++) begin
      sprite_enable[i] = act_q[i].en;
      x1_pos[i]        = act_q[i].x1;
      y1_pos[i]        = act_q[i].y1;
      x2_pos[i]        = act_q[i].x2;
      y2_pos[i]        = act_q[i].y2;
      ram_address[i]   = act_q[i].ra;
      layer[i]         = act_q[i].ly;
    end
  end

  assign wr_req  = wr_req_q;
  assign wr_add  = wr_add_q;
  assign wr_data = wr_data_q;

endmodule
